// File: rtl/speech256_pkg.sv
// Shared definitions for the Speech256 allophone load path.
//   ALLO_W        : allophone code width
//   DEFAULT_DEPTH : default allophone queue depth
//   PA1..PA5      : pause allophone codes
//   state_e       : load-handshake FSM state encoding
package speech256_pkg;

   localparam int unsigned ALLO_W        = 6;
   localparam int unsigned DEFAULT_DEPTH = 4;

   localparam logic [ALLO_W-1:0] PA1 = 6'h00;
   localparam logic [ALLO_W-1:0] PA2 = 6'h01;
   localparam logic [ALLO_W-1:0] PA3 = 6'h02;
   localparam logic [ALLO_W-1:0] PA4 = 6'h03;
   localparam logic [ALLO_W-1:0] PA5 = 6'h04;

   typedef enum logic [1:0] {
      S_READY = 2'd0,
      S_HOLD  = 2'd1
   } state_e;

endpackage

// File: rtl/speech256_fifo.sv
// Register-array FIFO with synchronous reset and flush.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   flush_i          : synchronous clear (wins over push/pop)
//   push_i, wdata_i  : write request and data (ignored when full)
//   pop_i            : read advance (ignored when empty)
//   rdata_o          : head-of-queue entry
//   level_o          : number of stored entries (0..Depth)
//   full_o, empty_o  : status flags
module speech256_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 6,
   parameter int unsigned Aw    = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic [Aw:0]      level_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam logic [Aw:0] FullLevel = (Aw+1)'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [Aw-1:0]    wr_ptr_q, wr_ptr_d;
   logic [Aw-1:0]    rd_ptr_q, rd_ptr_d;
   logic [Aw:0]      level_q, level_d;
   logic             push_ok, pop_ok;

   assign full_o  = (level_q == FullLevel);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign push_ok = push_i && !full_o && !flush_i;
   assign pop_ok  = pop_i && !empty_o && !flush_i;

   // Depth is a power of two, so pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + Aw'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + Aw'(1);
         level_d = level_q + (Aw+1)'(push_ok) - (Aw+1)'(pop_ok);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: entries are only observed once written.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/speech256_allophone_queue.sv
// Loader-side responder for the Speech256 allophone load interface.
// Answers the host data_stb/ldq handshake, buffers codes in a FIFO and
// presents them in order to the sequencer over valid/ready.
//   clk, rst            : clock, synchronous active-high reset
//   data_in, data_stb   : host allophone code and one-cycle load strobe
//   flush               : synchronous queue clear
//   ldq                 : registered load request (host may strobe while high)
//   allo_data/valid     : head-of-queue code and non-empty flag
//   allo_ready          : sequencer consumes allo_data this cycle
//   level               : current number of entries
//   overflow            : sticky, a strobe arrived while ldq was low
module speech256_allophone_queue
   import speech256_pkg::*;
#(
   parameter int unsigned DEPTH          = DEFAULT_DEPTH,
   parameter int unsigned AW             = 2,
   parameter int unsigned LDQ_LOW_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ALLO_W-1:0] data_in,
   input  logic              data_stb,
   input  logic              flush,
   output logic              ldq,
   output logic [ALLO_W-1:0] allo_data,
   output logic              allo_valid,
   input  logic              allo_ready,
   output logic [AW:0]       level,
   output logic              overflow
);

   localparam int unsigned CntW = (LDQ_LOW_CYCLES > 1) ? $clog2(LDQ_LOW_CYCLES) : 1;
   localparam logic [CntW-1:0] HoldInit  = CntW'(LDQ_LOW_CYCLES - 1);
   localparam logic [AW:0]     FullLevel = (AW+1)'(DEPTH);

   state_e          state_q, state_d;
   logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
   logic            ldq_q, ldq_d;
   logic            ovf_q, ovf_d;

   logic            fifo_full, fifo_empty;
   logic            accept, reject, pop;
   logic [AW:0]     next_level;

   // fifo_full is redundant with ldq gating; kept as a guard against overfill.
   assign accept = data_stb && ldq_q && !fifo_full && !flush;
   assign reject = data_stb && !ldq_q && !flush;
   assign pop    = !fifo_empty && allo_ready && !flush;

   assign next_level = flush ? '0 : (level + (AW+1)'(accept) - (AW+1)'(pop));

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      ovf_d      = ovf_q | reject;
      if (flush) begin
         state_d    = S_READY;
         hold_cnt_d = '0;
         ovf_d      = 1'b0;
      end else begin
         case (state_q)
            S_READY: begin
               if (accept) begin
                  state_d    = S_HOLD;
                  hold_cnt_d = HoldInit;
               end
            end
            S_HOLD: begin
               if (hold_cnt_q == '0) state_d = S_READY;
               else                  hold_cnt_d = hold_cnt_q - CntW'(1);
            end
            default: state_d = S_READY;
         endcase
      end
      // Registered so ldq never depends combinationally on data_stb.
      ldq_d = (state_d == S_READY) && (next_level < FullLevel);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_READY;
         hold_cnt_q <= '0;
         ldq_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         ldq_q      <= ldq_d;
         ovf_q      <= ovf_d;
      end
   end

   speech256_fifo #(
      .Depth (DEPTH),
      .Width (ALLO_W),
      .Aw    (AW)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .push_i  (accept),
      .wdata_i (data_in),
      .pop_i   (pop),
      .rdata_o (allo_data),
      .level_o (level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign ldq        = ldq_q;
   assign allo_valid = !fifo_empty;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_speech256_allophone_queue.sv
module tb_speech256_allophone_queue;

   localparam int DEPTH   = 4;
   localparam int AW      = 2;
   localparam int LDQ_LOW = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] data_in = '0;
   logic       data_stb = 1'b0;
   logic       flush = 1'b0;
   logic       ldq;
   logic [5:0] allo_data;
   logic       allo_valid;
   logic       allo_ready = 1'b0;
   logic [AW:0] level;
   logic       overflow;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   speech256_allophone_queue #(
      .DEPTH          (DEPTH),
      .AW             (AW),
      .LDQ_LOW_CYCLES (LDQ_LOW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_stb   (data_stb),
      .flush      (flush),
      .ldq        (ldq),
      .allo_data  (allo_data),
      .allo_valid (allo_valid),
      .allo_ready (allo_ready),
      .level      (level),
      .overflow   (overflow)
   );

   // Behavioural model: a queue of codes plus "cycles of low ldq still owed".
   int   mq[$];
   logic m_ldq = 1'b0;
   logic m_ovf = 1'b0;
   int   m_hold = 0;

   function automatic void model_step();
      logic acc, rej, pp;
      if (rst) begin
         mq.delete(); m_ovf = 1'b0; m_hold = 0; m_ldq = 1'b0;
      end else if (flush) begin
         mq.delete(); m_ovf = 1'b0; m_hold = 0; m_ldq = 1'b1;
      end else begin
         acc = data_stb && m_ldq;
         rej = data_stb && !m_ldq;
         pp  = (mq.size() > 0) && allo_ready;
         if (pp) void'(mq.pop_front());
         if (acc) mq.push_back(int'(data_in));
         if (rej) m_ovf = 1'b1;
         if (acc) m_hold = LDQ_LOW;
         else if (m_hold > 0) m_hold--;
         m_ldq = (m_hold == 0) && (mq.size() < DEPTH);
      end
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".ldq"}, 32'(ldq), 32'(m_ldq));
      chk({tag, ".valid"}, 32'(allo_valid), 32'(mq.size() != 0));
      chk({tag, ".level"}, 32'(level), 32'(mq.size()));
      chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      if (mq.size() != 0) chk({tag, ".data"}, 32'(allo_data), 32'(mq[0]));
   endtask

   typedef struct {
      logic       rst, fl, stb;
      logic [5:0] d;
      logic       rdy;
      logic       e_ldq, e_valid;
      logic [2:0] e_lvl;
      logic       e_ovf;
      logic [5:0] e_d;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic f, input logic s, input logic [5:0] d,
                      input logic rd, input logic el, input logic ev, input logic [2:0] elv,
                      input logic eo, input logic [5:0] ed);
      vec_t v;
      v.rst = r; v.fl = f; v.stb = s; v.d = d; v.rdy = rd;
      v.e_ldq = el; v.e_valid = ev; v.e_lvl = elv; v.e_ovf = eo; v.e_d = ed;
      vecs.push_back(v);
   endtask

   logic [5:0] codes [5] = '{6'h1B, 6'h07, 6'h2D, 6'h35, 6'h03};

   typedef enum {H_IDLE, H_ALLO, H_WAIT} host_e;

   initial begin
      // rst fl stb data rdy | ldq valid level ovf data
      add(1,0,0,6'h00,0, 0,0,0,0,6'h00);  // reset held 3 cycles
      add(1,0,0,6'h00,0, 0,0,0,0,6'h00);
      add(1,0,0,6'h00,0, 0,0,0,0,6'h00);
      add(0,0,0,6'h00,0, 1,0,0,0,6'h00);  // ldq rises after release
      add(0,0,1,6'h1B,0, 0,1,1,0,6'h1B);  // single load
      add(0,0,0,6'h00,0, 0,1,1,0,6'h1B);
      add(0,0,0,6'h00,0, 1,1,1,0,6'h1B);  // exactly 2 low cycles
      add(0,0,0,6'h00,1, 1,0,0,0,6'h00);  // drain
      add(0,0,1,6'h21,0, 0,1,1,0,6'h21);  // fill
      add(0,0,0,6'h00,0, 0,1,1,0,6'h21);
      add(0,0,0,6'h00,0, 1,1,1,0,6'h21);
      add(0,0,1,6'h14,0, 0,1,2,0,6'h21);
      add(0,0,0,6'h00,0, 0,1,2,0,6'h21);
      add(0,0,0,6'h00,0, 1,1,2,0,6'h21);
      add(0,0,1,6'h00,0, 0,1,3,0,6'h21);
      add(0,0,0,6'h00,0, 0,1,3,0,6'h21);
      add(0,0,0,6'h00,0, 1,1,3,0,6'h21);
      add(0,0,1,6'h2B,0, 0,1,4,0,6'h21);
      add(0,0,0,6'h00,0, 0,1,4,0,6'h21);
      add(0,0,0,6'h00,0, 0,1,4,0,6'h21);  // hold expired but full
      add(0,0,0,6'h00,0, 0,1,4,0,6'h21);
      add(0,0,0,6'h00,1, 1,1,3,0,6'h14);  // pop lifts ldq next cycle
      add(0,0,1,6'h07,0, 0,1,4,0,6'h14);
      add(0,0,1,6'h3E,0, 0,1,4,1,6'h14);  // strobe during hold -> overflow
      add(0,0,0,6'h00,0, 0,1,4,1,6'h14);
      add(0,0,0,6'h00,0, 0,1,4,1,6'h14);  // sticky
      add(0,1,0,6'h00,0, 1,0,0,0,6'h00);  // flush
      add(0,0,0,6'h00,0, 1,0,0,0,6'h00);
      add(0,0,1,6'h07,0, 0,1,1,0,6'h07);  // level 1, head 07
      add(0,0,0,6'h00,0, 0,1,1,0,6'h07);
      add(0,0,0,6'h00,0, 1,1,1,0,6'h07);
      add(0,0,1,6'h2D,1, 0,1,1,0,6'h2D);  // simultaneous accept + pop
      add(0,0,0,6'h00,0, 0,1,1,0,6'h2D);
      add(0,0,0,6'h00,0, 1,1,1,0,6'h2D);
      add(0,1,1,6'h3F,1, 1,0,0,0,6'h00);  // flush beats strobe and pop
      add(0,0,0,6'h00,1, 1,0,0,0,6'h00);  // ready while empty
      add(0,0,1,6'h05,0, 0,1,1,0,6'h05);
      add(1,0,0,6'h00,0, 0,0,0,0,6'h00);  // reset mid-hold
      add(0,0,0,6'h00,0, 1,0,0,0,6'h00);
      add(0,0,1,6'h09,0, 0,1,1,0,6'h09);
      add(0,1,0,6'h00,0, 1,0,0,0,6'h00);  // flush mid-hold

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; flush = vecs[i].fl; data_stb = vecs[i].stb;
         data_in = vecs[i].d; allo_ready = vecs[i].rdy;
         tick();
         chk($sformatf("vec%0d.ldq", i), 32'(ldq), 32'(vecs[i].e_ldq));
         chk($sformatf("vec%0d.valid", i), 32'(allo_valid), 32'(vecs[i].e_valid));
         chk($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].e_lvl));
         chk($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
         if (vecs[i].e_valid) chk($sformatf("vec%0d.data", i), 32'(allo_data), 32'(vecs[i].e_d));
      end

      // Host FSM streaming against a slow sequencer.
      begin
         host_e      hs = H_IDLE;
         int         idx = 0;
         int         stuck = 0;
         int         wait_run = 0;
         int         max_wait = 0;
         logic [5:0] got[$];
         rst = 0; flush = 1; data_stb = 0; allo_ready = 0;
         tick();
         flush = 0;
         for (int cyc = 0; cyc < 400 && got.size() < 5; cyc++) begin
            allo_ready = ((cyc % 7) == 6);
            if (allo_ready && allo_valid) got.push_back(allo_data);
            data_stb = 1'b0;
            case (hs)
               H_IDLE: if (idx < 5 && ldq) begin
                  data_in = codes[idx]; data_stb = 1'b1; idx++; hs = H_ALLO;
               end
               H_ALLO: if (!ldq) hs = H_WAIT; else begin stuck++; hs = H_WAIT; end
               default: begin
                  if (ldq) begin hs = H_IDLE; wait_run = 0; end
                  else begin wait_run++; if (wait_run > max_wait) max_wait = wait_run; end
               end
            endcase
            tick();
            check_model("host");
         end
         allo_ready = 0; data_stb = 0;
         chk("host.count", 32'(got.size()), 32'd5);
         for (int i = 0; i < got.size() && i < 5; i++)
            chk($sformatf("host.code%0d", i), 32'(got[i]), 32'(codes[i]));
         chk("host.ovf", 32'(overflow), 32'd0);
         chk("host.ldq_low_seen", 32'(stuck), 32'd0);
         chk("host.wait_bounded", 32'(max_wait <= DEPTH * 7 + LDQ_LOW), 32'd1);
      end

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 199) == 0);
         flush      = ($urandom_range(0, 49) == 0);
         data_stb   = ($urandom_range(0, 1) == 1);
         data_in    = 6'($urandom);
         allo_ready = ($urandom_range(0, 2) == 0);
         tick();
         check_model($sformatf("rnd%0d", i));
      end
      rst = 0; flush = 0; data_stb = 0; allo_ready = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
